// File: rtl/mmss_countdown_timer_if.sv
// Button and display-digit bundle between the countdown timer and its user.
// The bench or board drives the raw buttons; the display driver consumes the rest.
interface mmss_countdown_timer_if;
  logic       btn_start;
  logic       btn_clear;
  logic       btn_min;
  logic       btn_sec;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] C;
  logic [3:0] D;
  logic [0:3] dots;
  logic       flashing;
  logic       running;

  modport master (
    output btn_start, btn_clear, btn_min, btn_sec,
    input  A, B, C, D, dots, flashing, running
  );

  modport slave (
    input  btn_start, btn_clear, btn_min, btn_sec,
    output A, B, C, D, dots, flashing, running
  );
endinterface

// File: rtl/mmss_countdown_timer.sv
// MM:SS countdown timer: debounced buttons, BCD setting and 1 Hz countdown,
// with digit, colon and flash outputs for a four-digit seven-segment driver.
module mmss_countdown_timer #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mmss_countdown_timer_if.slave bus
);
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

  localparam int B_CLEAR = 0;
  localparam int B_START = 1;
  localparam int B_MIN   = 2;
  localparam int B_SEC   = 3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  typedef struct packed {
    logic [3:0] a;  // minutes tens
    logic [3:0] b;  // minutes units
    logic [3:0] c;  // seconds tens
    logic [3:0] d;  // seconds units
  } mmss_t;

  // ---------------------------------------------------------------------------
  // Button conditioning: 2-flop synchronizer, debounce counter, rising pulse
  // ---------------------------------------------------------------------------
  logic [3:0]    raw, sync1_q, sync2_q, level_q, pulse_q;
  logic [DW-1:0] db_cnt_q [4];

  assign raw = {bus.btn_sec, bus.btn_min, bus.btn_start, bus.btn_clear};

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      pulse_q <= '0;
      // NOTE: this small array is four counters built from flops, not a RAM,
      // so it is reset like any other register.
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      pulse_q <= '0;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_cnt_q[i] <= '0;
          level_q[i]  <= sync2_q[i];
          pulse_q[i]  <= sync2_q[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Only the highest-priority pulse acts: clear > start > min > sec.
  logic act_clear, act_start, act_min, act_sec;
  assign act_clear = pulse_q[B_CLEAR];
  assign act_start = pulse_q[B_START] & ~pulse_q[B_CLEAR];
  assign act_min   = pulse_q[B_MIN] & ~pulse_q[B_START] & ~pulse_q[B_CLEAR];
  assign act_sec   = pulse_q[B_SEC] & ~pulse_q[B_MIN] & ~pulse_q[B_START] & ~pulse_q[B_CLEAR];

  // ---------------------------------------------------------------------------
  // BCD arithmetic
  // ---------------------------------------------------------------------------
  function automatic mmss_t inc_min(input mmss_t t);
    mmss_t r = t;
    if (t.b == 4'd9) begin
      r.b = 4'd0;
      r.a = (t.a == 4'd9) ? 4'd0 : t.a + 4'd1;
    end else begin
      r.b = t.b + 4'd1;
    end
    return r;
  endfunction

  // Seconds wrap 59 -> 00 without carrying into the minutes.
  function automatic mmss_t inc_sec(input mmss_t t);
    mmss_t r = t;
    if (t.d == 4'd9) begin
      r.d = 4'd0;
      r.c = (t.c == 4'd5) ? 4'd0 : t.c + 4'd1;
    end else begin
      r.d = t.d + 4'd1;
    end
    return r;
  endfunction

  function automatic mmss_t dec_time(input mmss_t t);
    mmss_t r = t;
    if (t.d != 4'd0) begin
      r.d = t.d - 4'd1;
    end else begin
      r.d = 4'd9;
      if (t.c != 4'd0) begin
        r.c = t.c - 4'd1;
      end else begin
        r.c = 4'd5;
        if (t.b != 4'd0) begin
          r.b = t.b - 4'd1;
        end else begin
          r.b = 4'd9;
          r.a = t.a - 4'd1;
        end
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Control FSM, time register and prescaler
  // ---------------------------------------------------------------------------
  state_t        state_q, state_d;
  mmss_t         time_q, time_d, time_dec;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic          colon_q, flashing_q, running_q;

  assign time_dec = dec_time(time_q);
  assign tick     = (state_q == S_RUN) && (presc_q == PRESC_LAST);

  // NOTE: every variable is given a default before the case statement, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    presc_d = presc_q;
    unique case (state_q)
      S_IDLE: begin
        presc_d = '0;
        if (act_clear)                       time_d = '0;
        else if (act_start && time_q != '0)  state_d = S_RUN;
        else if (act_min)                    time_d = inc_min(time_q);
        else if (act_sec)                    time_d = inc_sec(time_q);
      end
      S_RUN: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (act_clear) begin
          state_d = S_IDLE;
          time_d  = '0;
          presc_d = '0;
        end else if (act_start) begin
          // The pause edge itself does not count; a coincident tick is dropped.
          state_d = S_PAUSE;
          presc_d = tick ? '0 : presc_q;
        end else if (tick) begin
          time_d = time_dec;
          if (time_dec == '0) state_d = S_DONE;
        end
      end
      S_PAUSE: begin
        if (act_clear) begin
          state_d = S_IDLE;
          time_d  = '0;
          presc_d = '0;
        end else if (act_start) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        presc_d = '0;
        time_d  = '0;
        if (act_clear || act_start) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        time_d  = '0;
        presc_d = '0;
      end
    endcase
  end

  // Status outputs are registered from next-state values so they change on the
  // same edge as the state and carry no decode glitches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      time_q     <= '0;
      presc_q    <= '0;
      colon_q    <= 1'b1;
      flashing_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      presc_q    <= presc_d;
      colon_q    <= (state_d != S_RUN) || (presc_d < PRESC_HALF);
      flashing_q <= (state_d == S_PAUSE) || (state_d == S_DONE);
      running_q  <= (state_d == S_RUN);
    end
  end

  assign bus.A        = time_q.a;
  assign bus.B        = time_q.b;
  assign bus.C        = time_q.c;
  assign bus.D        = time_q.d;
  assign bus.dots     = {1'b0, colon_q, 2'b00};
  assign bus.flashing = flashing_q;
  assign bus.running  = running_q;
endmodule

// File: tb/tb_mmss_countdown_timer.sv
// Self-checking bench for mmss_countdown_timer with CLK_HZ=10, DEBOUNCE_CYCLES=4:
// vector table for setting, directed timing sequences, randomized set/run model.
module tb_mmss_countdown_timer;
  localparam int CLK_HZ = 10;
  localparam int DB     = 4;

  localparam logic [3:0] M_CLEAR = 4'b1000;
  localparam logic [3:0] M_START = 4'b0100;
  localparam logic [3:0] M_MIN   = 4'b0010;
  localparam logic [3:0] M_SEC   = 4'b0001;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  mmss_countdown_timer_if bus ();

  mmss_countdown_timer #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DB)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  mask;
    int          reps;
    logic [15:0] exp_time;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] bcd(input int m, input int s);
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] shown();
    return {bus.A, bus.B, bus.C, bus.D};
  endfunction

  task automatic drive(input logic [3:0] m);
    {bus.btn_clear, bus.btn_start, bus.btn_min, bus.btn_sec} = m;
  endtask

  // Clean press: held well past the debounce window, then released just as long.
  task automatic press(input logic [3:0] m);
    drive(m);
    repeat (8) @(negedge clk);
    drive(4'b0000);
    repeat (8) @(negedge clk);
  endtask

  task automatic set_time(input int m, input int s);
    press(M_CLEAR);
    repeat (m) press(M_MIN);
    repeat (s) press(M_SEC);
  endtask

  // Returns at the first sample where running is seen (sample n=0 of the run).
  task automatic start_run();
    bit ok = 0;
    drive(M_START);
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = bus.running;
    end
    drive(4'b0000);
    check("run_entered", ok, 1);
  endtask

  // Pause by a start press raised at sample press_at, hold 50 cycles, resume,
  // and measure how long the next decrement takes.
  task automatic pause_resume(input int press_at, input int exp_presc, input string tag);
    int k = 0, p, errs = 0, m = 0, rem;
    bit seen = 0;
    logic [15:0] held;
    set_time(0, 5);
    start_run();
    for (int n = 0; n < 200; n++) begin
      if (!bus.running) break;
      k++;
      if (n == press_at) drive(M_START);
      @(negedge clk);
    end
    drive(4'b0000);
    p   = (k - 1) % CLK_HZ;
    rem = 5 - (k - 1) / CLK_HZ;
    check({tag, "_prescaler_at_pause"}, p, exp_presc);
    check({tag, "_paused_time"}, shown(), bcd(0, rem));
    for (int i = 0; i < 50; i++) begin
      if (shown() !== bcd(0, rem) || bus.flashing !== 1'b1 || bus.running !== 1'b0) errs++;
      @(negedge clk);
    end
    check({tag, "_pause_hold"}, errs, 0);
    start_run();
    held = shown();
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      m++;
      seen = (shown() !== held);
    end
    check({tag, "_resume_latency"}, m, (p == CLK_HZ - 1) ? CLK_HZ : CLK_HZ - p);
    check({tag, "_resume_time"}, shown(), bcd(0, rem - 1));
    press(M_CLEAR);
  endtask

  initial begin
    vec_t vecs[$];
    int m, s, total, k, rem, errs_t, errs_d, rises, rises_toggle;
    logic [3:0] mask;
    logic prev;

    vecs.push_back(vec_t'{M_MIN,           1,   16'h0100});
    vecs.push_back(vec_t'{M_SEC,           1,   16'h0101});
    vecs.push_back(vec_t'{M_MIN | M_SEC,   1,   16'h0201});
    vecs.push_back(vec_t'{M_SEC,           58,  16'h0259});
    vecs.push_back(vec_t'{M_SEC,           1,   16'h0200});
    vecs.push_back(vec_t'{M_MIN,           97,  16'h9900});
    vecs.push_back(vec_t'{M_MIN,           1,   16'h0000});
    vecs.push_back(vec_t'{M_START,         1,   16'h0000});
    vecs.push_back(vec_t'{M_SEC,           3,   16'h0003});
    vecs.push_back(vec_t'{M_CLEAR | M_MIN | M_SEC, 1, 16'h0000});
    vecs.push_back(vec_t'{M_MIN,           3,   16'h0300});
    vecs.push_back(vec_t'{M_SEC,           61,  16'h0301});
    vecs.push_back(vec_t'{M_MIN,           100, 16'h0301});
    vecs.push_back(vec_t'{M_CLEAR | M_START, 1, 16'h0000});

    drive(4'b0000);
    #12;
    check("in_reset_time", shown(), 16'h0000);
    check("in_reset_dots", bus.dots, 4'b0100);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_time", shown(), 16'h0000);
    check("reset_dots", bus.dots, 4'b0100);
    check("reset_flashing", bus.flashing, 0);
    check("reset_running", bus.running, 0);

    // Setting in IDLE, including priority and wrap cases.
    foreach (vecs[i]) begin
      repeat (vecs[i].reps) press(vecs[i].mask);
      check($sformatf("vec%0d_time", i), shown(), vecs[i].exp_time);
      check($sformatf("vec%0d_idle", i), {bus.running, bus.flashing}, 2'b00);
    end

    // Countdown 01:00 -> 00:00 with borrow and colon blink.
    set_time(1, 0);
    start_run();
    errs_t = 0;
    errs_d = 0;
    for (int n = 0; n < 600; n++) begin
      rem = 60 - n / CLK_HZ;
      if (shown() !== bcd(rem / 60, rem % 60) || bus.running !== 1'b1) errs_t++;
      if (bus.dots !== {1'b0, ((n % CLK_HZ) < CLK_HZ / 2), 2'b00}) errs_d++;
      if (n == 10) check("first_borrow", shown(), 16'h0059);
      @(negedge clk);
    end
    check("countdown_trace", errs_t, 0);
    check("colon_blink", errs_d, 0);
    check("done_time", shown(), 16'h0000);
    check("done_flashing", bus.flashing, 1);
    check("done_running", bus.running, 0);
    check("done_dots", bus.dots, 4'b0100);
    press(M_START);
    check("done_start_to_idle", {bus.running, bus.flashing}, 2'b00);

    // Bounce rejection on start.
    set_time(0, 5);
    rises = 0;
    prev  = bus.running;
    bus.btn_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) bus.btn_start = ~bus.btn_start;
      @(negedge clk);
      if (bus.running && !prev) rises++;
      prev = bus.running;
    end
    rises_toggle = rises;
    bus.btn_start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.running && !prev) rises++;
      prev = bus.running;
    end
    drive(4'b0000);
    check("bounce_no_run", rises_toggle, 0);
    check("bounce_single_start", rises, 1);
    check("bounce_running", bus.running, 1);
    press(M_CLEAR);

    // Pause at prescaler 6, and a pause coincident with a tick.
    pause_resume(10, 6, "pause6");
    pause_resume(13, CLK_HZ - 1, "pause_on_tick");

    // Clear and start in the same cycle while running.
    set_time(0, 9);
    start_run();
    repeat (8) @(negedge clk);
    press(M_CLEAR | M_START);
    check("clear_start_time", shown(), 16'h0000);
    check("clear_start_idle", {bus.running, bus.flashing}, 2'b00);

    // Randomized setting plus short runs against a seconds-level model.
    for (int it = 0; it < 4; it++) begin
      press(M_CLEAR);
      m = 0;
      s = 0;
      for (int j = 0; j < 10; j++) begin
        mask = 4'($urandom_range(0, 15)) & 4'b1011;
        if (mask[3] && $urandom_range(0, 3) != 0) mask[3] = 1'b0;
        if (mask == 4'b0000) mask = M_SEC;
        k = mask[3] ? 1 : $urandom_range(1, 12);
        repeat (k) begin
          press(mask);
          if (mask[3])      begin m = 0; s = 0; end
          else if (mask[1]) m = (m + 1) % 100;
          else              s = (s + 1) % 60;
        end
      end
      check($sformatf("rand%0d_set", it), shown(), bcd(m, s));
      total = m * 60 + s;
      if (total != 0) begin
        start_run();
        k = $urandom_range(1, (total < 6) ? total : 6);
        repeat (k * CLK_HZ) @(negedge clk);
        rem = total - k;
        check($sformatf("rand%0d_run", it), shown(), bcd(rem / 60, rem % 60));
        check($sformatf("rand%0d_state", it), {bus.running, bus.flashing},
              (rem == 0) ? 2'b01 : 2'b10);
      end
    end

    // Asynchronous reset in the middle of a run at 12:34.
    set_time(12, 34);
    start_run();
    repeat (25) @(negedge clk);
    check("pre_reset_time", shown(), 16'h1232);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_time", shown(), 16'h0000);
    check("async_reset_dots", bus.dots, 4'b0100);
    check("async_reset_status", {bus.running, bus.flashing}, 2'b00);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    set_time(0, 2);
    start_run();
    repeat (9) @(negedge clk);
    check("post_reset_no_early_tick", shown(), 16'h0002);
    @(negedge clk);
    check("post_reset_first_tick", shown(), 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
